// File: rtl/pc_trace_uart_if.sv
// Capture-side and status signals of pc_trace_uart, bundled for the FPGA top.
// slave = the trace reader, master = whoever feeds the core's debug outputs.
interface pc_trace_uart_if #(
    parameter int DEPTH = 16
) ();
    logic [31:0]             i_pc_debug;
    logic                    i_insn_vld;
    logic                    i_enable;
    logic                    o_uart_tx;
    logic                    o_busy;
    logic                    o_overflow;
    logic [$clog2(DEPTH):0]  o_fifo_level;
    logic [15:0]             o_drop_cnt;

    modport slave (
        input  i_pc_debug, i_insn_vld, i_enable,
        output o_uart_tx, o_busy, o_overflow, o_fifo_level, o_drop_cnt
    );

    modport master (
        output i_pc_debug, i_insn_vld, i_enable,
        input  o_uart_tx, o_busy, o_overflow, o_fifo_level, o_drop_cnt
    );
endinterface

// File: rtl/pc_trace_uart.sv
// Commit-trace reader: FIFO of committed PCs, each sent as a 5-byte 8N1 UART frame (0xA5 + PC MSB first).
// Optional PC_TRACE_DROP_CNT_EN adds a saturating dropped-capture counter on o_drop_cnt.
module pc_trace_uart #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic            i_clk,
    input  logic            i_reset,
    pc_trace_uart_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t         state_q, state_d;
    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           ovf_q, ovf_d;
    logic [31:0]    frame_q, frame_d;
    logic [2:0]     byte_q, byte_d, bit_q, bit_d;
    logic [CW-1:0]  baud_q, baud_d;
    logic           tx_q, tx_d;
    logic           push_req, full, pop, push, drop, baud_end;
    logic [7:0]     cur_byte;

    function automatic logic [7:0] frame_byte(input logic [31:0] f, input logic [2:0] idx);
        case (idx)
            3'd1:    return f[31:24];
            3'd2:    return f[23:16];
            3'd3:    return f[15:8];
            3'd4:    return f[7:0];
            default: return 8'hA5;
        endcase
    endfunction

    always_comb begin
        push_req = bus.i_insn_vld & bus.i_enable;
        full     = (level_q == LW'(DEPTH));
        pop      = (state_q == S_IDLE) && (level_q != '0);
        // A full FIFO still accepts when the IDLE pop frees a slot on the same edge.
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
        ovf_d    = ovf_q | drop;
    end

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        byte_d   = byte_q;
        bit_d    = bit_q;
        baud_d   = baud_q;
        baud_end = (baud_q == CW'(CLKS_PER_BIT - 1));
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    frame_d = mem_q[rd_ptr_q];
                    byte_d  = 3'd0;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else bit_d = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q < 3'd4) begin
                        byte_d  = byte_q + 3'd1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
        endcase

        // Line level is registered from the next state so it changes on the same edge as the FSM.
        cur_byte = frame_byte(frame_d, byte_d);
        tx_d     = 1'b1;
        if (state_d == S_START) tx_d = 1'b0;
        else if (state_d == S_DATA) tx_d = cur_byte[bit_d];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            frame_q  <= '0;
            byte_q   <= '0;
            bit_q    <= '0;
            baud_q   <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            frame_q  <= frame_d;
            byte_q   <= byte_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            tx_q     <= tx_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.i_pc_debug;
    end

`ifdef PC_TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) drop_cnt_q <= '0;
        else drop_cnt_q <= drop_cnt_d;
    end

    assign bus.o_drop_cnt = drop_cnt_q;
`else
    assign bus.o_drop_cnt = '0;
`endif

    assign bus.o_uart_tx    = tx_q;
    assign bus.o_busy       = (level_q != '0) || (state_q != S_IDLE);
    assign bus.o_overflow   = ovf_q;
    assign bus.o_fifo_level = level_q;
endmodule

// File: tb/tb_pc_trace_uart.sv
// Bench for pc_trace_uart: vector table, directed corner sequences and random traffic,
// checked against a queue-level model and a UART line decoder.
module tb_pc_trace_uart;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int FRAME = 50 * CPB;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;

    pc_trace_uart_if #(.DEPTH(DEPTH)) bus ();

    pc_trace_uart #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a bounded queue, transmitter as a busy countdown of one frame.
    logic [31:0] m_q [$];
    logic [7:0]  exp_bytes [$];
    int          m_tx_rem = 0;
    bit          m_ovf    = 0;
    int          m_drop   = 0;
    bit          m_pop, m_req, m_full;
    logic [31:0] m_pc;

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_q.delete();
            exp_bytes.delete();
            m_tx_rem = 0;
            m_ovf    = 0;
            m_drop   = 0;
        end else begin
            m_pop  = (m_tx_rem == 0) && (m_q.size() > 0);
            m_req  = bus.i_insn_vld && bus.i_enable;
            m_full = (m_q.size() == DEPTH);
            if (m_pop) begin
                m_pc = m_q.pop_front();
                exp_bytes.push_back(8'hA5);
                exp_bytes.push_back(m_pc[31:24]);
                exp_bytes.push_back(m_pc[23:16]);
                exp_bytes.push_back(m_pc[15:8]);
                exp_bytes.push_back(m_pc[7:0]);
                m_tx_rem = FRAME;
            end else if (m_tx_rem > 0) begin
                m_tx_rem--;
            end
            if (m_req) begin
                if (!m_full || m_pop) begin
                    m_q.push_back(bus.i_pc_debug);
                end else begin
                    m_ovf = 1;
`ifdef PC_TRACE_DROP_CNT_EN
                    if (m_drop < 65535) m_drop++;
`endif
                end
            end
        end
    end

    // UART 8N1 decoder sampling mid-bit; each completed byte is matched against the model's stream.
    bit          d_act = 0;
    int          d_cnt = 0;
    int          d_k;
    logic [7:0]  d_byte;
    int          rx_cnt = 0;

    always @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            d_act = 0;
        end else begin
            if (!d_act) begin
                if (bus.o_uart_tx == 1'b0) begin
                    d_act = 1;
                    d_cnt = 0;
                end
            end else begin
                d_cnt++;
            end
            if (d_act && (d_cnt % CPB == CPB / 2)) begin
                d_k = d_cnt / CPB;
                if (d_k == 0) begin
                    check("rx_start_bit", bus.o_uart_tx, 1'b0);
                end else if (d_k <= 8) begin
                    d_byte[d_k-1] = bus.o_uart_tx;
                end else begin
                    check("rx_stop_bit", bus.o_uart_tx, 1'b1);
                    rx_cnt++;
                    if (exp_bytes.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rx_extra_byte: got 0x%0h expected none at %0t", d_byte, $time);
                    end else begin
                        check("rx_byte", d_byte, exp_bytes.pop_front());
                    end
                    d_act = 0;
                end
            end
        end
    end

    // Continuous output check against the model, away from the active edge.
    bit chk_en = 0;
    always @(negedge i_clk) begin
        if (chk_en && !i_reset) begin
            check("level", bus.o_fifo_level, m_q.size());
            check("busy", bus.o_busy, (m_q.size() != 0) || (m_tx_rem != 0));
            check("overflow", bus.o_overflow, m_ovf);
            check("drop_cnt", bus.o_drop_cnt, m_drop);
            if (m_tx_rem == 0) check("idle_line", bus.o_uart_tx, 1'b1);
            else if (m_tx_rem == FRAME) check("start_fall", bus.o_uart_tx, 1'b0);
        end
    end

    initial begin
        #990000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        vld;
        logic        en;
        logic [31:0] pc;
        int          lvl;
        logic        busy;
        logic        tx;
    } vec_t;

    vec_t vt [8];

    task automatic drive(input logic vld, input logic en, input logic [31:0] pc);
        bus.i_insn_vld = vld;
        bus.i_enable   = en;
        bus.i_pc_debug = pc;
    endtask

    task automatic do_reset();
        drive(0, 1, 32'h0);
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        drive(0, 1, 32'h0);
        while ((bus.o_busy || m_tx_rem != 0) && n < max_cycles) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_done", bus.o_busy, 1'b0);
        repeat (2) @(negedge i_clk);
        check("rx_all_bytes", exp_bytes.size(), 0);
    endtask

    int n;
    int rx_base;
    int p_vld;

    initial begin
        drive(0, 1, 32'h0);
        repeat (2) @(negedge i_clk);
        check("reset_tx", bus.o_uart_tx, 1'b1);
        check("reset_busy", bus.o_busy, 1'b0);
        check("reset_level", bus.o_fifo_level, 0);
        check("reset_overflow", bus.o_overflow, 1'b0);
        check("reset_drop", bus.o_drop_cnt, 0);
        i_reset = 1'b0;
        chk_en  = 1;

        // Vector table from reset: gating, first capture, immediate pop and start bit of 0xA5.
        vt[0] = '{1'b1, 1'b0, 32'h0000_0055, 0, 1'b0, 1'b1};
        vt[1] = '{1'b0, 1'b1, 32'h0000_0000, 0, 1'b0, 1'b1};
        vt[2] = '{1'b1, 1'b1, 32'h0000_1234, 1, 1'b1, 1'b1};
        vt[3] = '{1'b0, 1'b1, 32'h0000_0000, 0, 1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b1, 32'hCAFE_0004, 1, 1'b1, 1'b0};
        vt[5] = '{1'b1, 1'b1, 32'hCAFE_0008, 2, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b1, 32'h0000_0000, 2, 1'b1, 1'b0};
        vt[7] = '{1'b1, 1'b0, 32'h0000_0077, 2, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].vld, vt[i].en, vt[i].pc);
            @(negedge i_clk);
            check($sformatf("vec%0d_level", i), bus.o_fifo_level, vt[i].lvl);
            check($sformatf("vec%0d_busy", i), bus.o_busy, vt[i].busy);
            check($sformatf("vec%0d_tx", i), bus.o_uart_tx, vt[i].tx);
        end
        drain(4 * (FRAME + 1) + 50);

        // Single capture: fall one edge after capture, 200-cycle frame, then not busy.
        do_reset();
        drive(1, 1, 32'h0000_1234);
        @(negedge i_clk);
        drive(0, 1, 32'h0);
        check("single_capture_tx", bus.o_uart_tx, 1'b1);
        check("single_capture_level", bus.o_fifo_level, 1);
        @(negedge i_clk);
        check("single_start_fall", bus.o_uart_tx, 1'b0);
        n = 0;
        while (bus.o_busy && n < 1000) begin
            @(negedge i_clk);
            n++;
        end
        check("single_frame_len", n, FRAME);
        drain(10);

        // Enable gating.
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, $urandom);
            @(negedge i_clk);
            check("gate_level", bus.o_fifo_level, 0);
            check("gate_tx", bus.o_uart_tx, 1'b1);
            check("gate_overflow", bus.o_overflow, 1'b0);
            drive(0, 0, 32'h0);
            @(negedge i_clk);
        end

        // Overflow: 8 back-to-back captures, 5 accepted, 3 dropped.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 32'h100 + 32'(4 * i));
            @(negedge i_clk);
        end
        drive(0, 1, 32'h0);
        check("ovf_flag", bus.o_overflow, 1'b1);
        check("ovf_level", bus.o_fifo_level, DEPTH);
`ifdef PC_TRACE_DROP_CNT_EN
        check("ovf_drop_cnt", bus.o_drop_cnt, 3);
`else
        check("ovf_drop_cnt", bus.o_drop_cnt, 0);
`endif
        // Push on the very edge where IDLE pops a full FIFO.
        n = 0;
        while (m_tx_rem != 0 && n < FRAME + 10) begin
            @(negedge i_clk);
            n++;
        end
        check("full_wait_idle", bus.o_fifo_level, DEPTH);
        drive(1, 1, 32'h0000_0200);
        @(negedge i_clk);
        drive(0, 1, 32'h0);
        check("full_pushpop_level", bus.o_fifo_level, DEPTH);
        check("full_pushpop_tx", bus.o_uart_tx, 1'b0);
`ifdef PC_TRACE_DROP_CNT_EN
        check("full_pushpop_drop", bus.o_drop_cnt, 3);
`else
        check("full_pushpop_drop", bus.o_drop_cnt, 0);
`endif
        drain(6 * (FRAME + 1) + 50);

        // Reset during data bits of byte 2, then a clean new frame.
        do_reset();
        drive(1, 1, 32'h1234_5678);
        @(negedge i_clk);
        drive(0, 1, 32'h0);
        repeat (90) @(negedge i_clk);
        check("midframe_in_data", bus.o_busy, 1'b1);
        #2;
        i_reset = 1'b1;
        #1;
        check("midreset_tx", bus.o_uart_tx, 1'b1);
        check("midreset_busy", bus.o_busy, 1'b0);
        check("midreset_level", bus.o_fifo_level, 0);
        check("midreset_overflow", bus.o_overflow, 1'b0);
        check("midreset_drop", bus.o_drop_cnt, 0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        rx_base = rx_cnt;
        repeat (3) @(negedge i_clk);
        drive(1, 1, 32'hDEAD_BEEF);
        @(negedge i_clk);
        drive(0, 1, 32'h0);
        drain(FRAME + 50);
        check("midreset_rx_count", rx_cnt - rx_base, 5);

        // Random traffic in light and heavy phases.
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            p_vld = (ph % 2 == 0) ? 2 : 40;
            for (int i = 0; i < 800; i++) begin
                drive(($urandom_range(0, 99) < p_vld) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0, $urandom);
                @(negedge i_clk);
            end
        end
        drain((DEPTH + 1) * (FRAME + 1) + 50);

`ifdef PC_TRACE_DROP_CNT_EN
        do_reset();
        drive(1, 1, 32'h0000_ABCD);
        repeat (70000) @(negedge i_clk);
        check("sat_drop_cnt", bus.o_drop_cnt, 16'hFFFF);
        repeat (5) @(negedge i_clk);
        check("sat_no_wrap", bus.o_drop_cnt, 16'hFFFF);
        drive(0, 1, 32'h0);
`else
        do_reset();
        drive(1, 1, 32'h0000_ABCD);
        repeat (300) @(negedge i_clk);
        check("nomacro_drop_zero", bus.o_drop_cnt, 0);
        check("nomacro_overflow", bus.o_overflow, 1'b1);
        drive(0, 1, 32'h0);
`endif
        drain((DEPTH + 1) * (FRAME + 1) + 50);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
